block_memory: RTL

//  Block-granular backing data memory directly downstream of the set-associative cache.

---
 rtl/cache_pkg.sv | 19 +
 rtl/block_memory_if.sv | 29 ++
 rtl/block_mem_array.sv | 24 ++
 rtl/block_memory.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache / backing-memory pair: geometry defaults,
// derived bus widths and the block memory controller state encoding.
package cache_pkg;

  localparam int unsigned c_line_size      = 32;
  localparam int unsigned c_block_size     = 2;
  localparam int unsigned address_size     = 32;

  // Block width in bits and block address width (byte address minus word/byte offset)
  localparam int unsigned block_width      = (2 ** c_block_size) * c_line_size;
  localparam int unsigned block_addr_width = address_size - c_block_size - 2;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/block_memory_if.sv
// Cache <-> backing memory block transfer bus: level requests from the cache,
// busywait and one-cycle done pulses back from the memory.
interface block_memory_if #(
  parameter int unsigned bw = cache_pkg::block_width,
  parameter int unsigned aw = cache_pkg::block_addr_width
) ();

  logic          m_read_i;
  logic          m_wr_i;
  logic [aw-1:0] m_address_i;
  logic [bw-1:0] m_write_data_i;
  logic          m_busywait_o;
  logic [bw-1:0] m_read_data_o;
  logic          m_read_done_o;
  logic          m_write_done_o;

  // Cache side
  modport master (
    output m_read_i, m_wr_i, m_address_i, m_write_data_i,
    input  m_busywait_o, m_read_data_o, m_read_done_o, m_write_done_o
  );

  // Memory side
  modport slave (
    input  m_read_i, m_wr_i, m_address_i, m_write_data_i,
    output m_busywait_o, m_read_data_o, m_read_done_o, m_write_done_o
  );

endinterface

// File: rtl/block_mem_array.sv
// Single-port synchronous block storage: write-enable, registered read.
// Contents are deliberately not reset.
module block_mem_array #(
  parameter int unsigned width      = 128,
  parameter int unsigned depth_log2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [depth_log2-1:0] addr,
  input  logic [width-1:0]      wdata,
  output logic [width-1:0]      rdata
);

  logic [width-1:0] mem [0:(1 << depth_log2) - 1];

  // Commit writes and register the addressed block every cycle (read-first)
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/block_memory.sv
// Block-granular backing memory behind the set-associative cache. Accepts one
// refill or write-back at a time, completes it a fixed number of cycles later,
// and ignores the cache's trailing request cycle until the lines drop low.
module block_memory
  import cache_pkg::*;
#(
  parameter int unsigned c_line_size    = cache_pkg::c_line_size,
  parameter int unsigned c_block_size   = cache_pkg::c_block_size,
  parameter int unsigned address_size   = cache_pkg::address_size,
  parameter int unsigned mem_depth_log2 = 10,
  parameter int unsigned latency        = 4
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  block_memory_if.slave  bus
);

  localparam int unsigned bw = (2 ** c_block_size) * c_line_size;
  localparam int unsigned aw = address_size - c_block_size - 2;

  mem_state_e state, state_next;

  logic                      armed, armed_next;
  logic [7:0]                counter, counter_next;
  logic [mem_depth_log2-1:0] addr_q, addr_next;
  logic [bw-1:0]             wdata_q, wdata_next;
  logic                      op_wr, op_wr_next;
  logic                      busywait, busywait_next;
  logic [bw-1:0]             read_data, read_data_next;
  logic                      read_done, read_done_next;
  logic                      write_done, write_done_next;

  logic                      mem_we;
  logic [mem_depth_log2-1:0] mem_addr;
  logic [bw-1:0]             mem_rdata;

  // Block address bits above the array depth alias onto the same entries
  logic addr_high_unused;
  assign addr_high_unused = ^bus.m_address_i[aw-1:mem_depth_log2];

  // While idle the array looks at the live request address so the registered
  // read is already valid after the accept edge; during BUSY it uses the latch.
  assign mem_addr = (state == MEM_IDLE) ? bus.m_address_i[mem_depth_log2-1:0] : addr_q;

  block_mem_array #(
    .width      (bw),
    .depth_log2 (mem_depth_log2)
  ) u_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Next-state, arming, latency counter and next output values
  always_comb begin
    state_next      = state;
    armed_next      = armed;
    counter_next    = counter;
    addr_next       = addr_q;
    wdata_next      = wdata_q;
    op_wr_next      = op_wr;
    busywait_next   = busywait;
    read_data_next  = read_data;
    read_done_next  = 1'b0;
    write_done_next = 1'b0;
    mem_we          = 1'b0;

    case (state)
      MEM_IDLE: begin
        if (armed && (bus.m_wr_i || bus.m_read_i)) begin
          // Write-back wins over refill when both are requested
          addr_next     = bus.m_address_i[mem_depth_log2-1:0];
          wdata_next    = bus.m_write_data_i;
          op_wr_next    = bus.m_wr_i;
          counter_next  = 8'(latency - 1);
          busywait_next = 1'b1;
          state_next    = MEM_BUSY;
        end else if (!bus.m_wr_i && !bus.m_read_i) begin
          armed_next = 1'b1;
        end else begin
          armed_next = armed;
        end
      end
      MEM_BUSY: begin
        if (counter == 8'd0) begin
          busywait_next = 1'b0;
          armed_next    = 1'b0;
          state_next    = MEM_DONE;
          if (op_wr) begin
            mem_we          = 1'b1;
            write_done_next = 1'b1;
          end else begin
            read_data_next = mem_rdata;
            read_done_next = 1'b1;
          end
        end else begin
          counter_next = counter - 8'd1;
        end
      end
      MEM_DONE: begin
        state_next = MEM_IDLE;
      end
      default: begin
        state_next    = MEM_IDLE;
        busywait_next = 1'b0;
      end
    endcase
  end

  // State and output registers; array contents are outside this reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= MEM_IDLE;
      armed      <= 1'b1;
      counter    <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_wr      <= 1'b0;
      busywait   <= 1'b0;
      read_data  <= '0;
      read_done  <= 1'b0;
      write_done <= 1'b0;
    end else begin
      state      <= state_next;
      armed      <= armed_next;
      counter    <= counter_next;
      addr_q     <= addr_next;
      wdata_q    <= wdata_next;
      op_wr      <= op_wr_next;
      busywait   <= busywait_next;
      read_data  <= read_data_next;
      read_done  <= read_done_next;
      write_done <= write_done_next;
    end
  end

  assign bus.m_busywait_o   = busywait;
  assign bus.m_read_data_o  = read_data;
  assign bus.m_read_done_o  = read_done;
  assign bus.m_write_done_o = write_done;

endmodule
